// File: rtl/sqw_period_sequencer.sv
// sqw_period_sequencer: measurement controller for the square-wave input path.
// When armed it waits for the first synchronised rising edge of iSquareWave.
// It then times 2^AVG_LOG2 consecutive full periods and reports the truncated
// average, in iClk cycles, with a one-cycle oValid strobe.
// It supports single-shot or continuous re-arm, abort, and a no-signal timeout.
// Optional build macro: SQW_DUTY_EN adds averaged high-time measurement on oHigh.
// When the macro is undefined, oHigh is tied to 0.
module sqw_period_sequencer #(
  parameter int CNT_W       = 20,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 200000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSquareWave,
  input  logic             iStart,
  input  logic             iContinuous,
  input  logic             iAbort,
  output logic             oBusy,
  output logic [1:0]       oState,
  output logic [CNT_W-1:0] oPeriod,
  output logic [CNT_W-1:0] oHigh,
  output logic             oValid,
  output logic             oTimeout
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int IDX_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Accumulate one period-sized sample; the extra AVG_LOG2 bits absorb the sum.
  function automatic logic [ACC_W-1:0] accAdd(input logic [ACC_W-1:0] a,
                                               input logic [CNT_W-1:0] s);
    return a + ACC_W'(s);
  endfunction

  // Divide by the number of periods averaged, truncating toward zero.
  function automatic logic [CNT_W-1:0] truncAvg(input logic [ACC_W-1:0] a);
    return a[ACC_W-1:AVG_LOG2];
  endfunction

  state_t                 state;
  logic                   contQ;
  logic [SYNC_STAGES-1:0] sqwSync_p0;
  logic                   sqwPrev_p1;
  logic                   rise;
  logic [CNT_W-1:0]       perCnt;
  logic [CNT_W-1:0]       periodSample;
  logic [ACC_W-1:0]       perAcc;
  logic [IDX_W-1:0]       idx;
  logic [TMO_W-1:0]       tmoCnt;

  // Synchroniser chain followed by the edge-detect register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sqwSync_p0 <= '0;
      sqwPrev_p1 <= 1'b0;
    end else begin
      sqwSync_p0 <= {sqwSync_p0[SYNC_STAGES-2:0], iSquareWave};
      sqwPrev_p1 <= sqwSync_p0[SYNC_STAGES-1];
    end
  end

  assign rise = sqwSync_p0[SYNC_STAGES-1] & ~sqwPrev_p1;

  // Length of the period just closed: counter+1, or full scale once saturated.
  assign periodSample = satInc(perCnt);

  assign oState = state;
  assign oBusy  = (state != IDLE);

  // Main controller: state, period timing, timeout and result registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      contQ    <= 1'b0;
      perCnt   <= '0;
      perAcc   <= '0;
      idx      <= '0;
      tmoCnt   <= '0;
      oPeriod  <= '0;
      oValid   <= 1'b0;
      oTimeout <= 1'b0;
    end else begin
      oValid   <= 1'b0;
      oTimeout <= 1'b0;
      if (iAbort) begin
        state <= IDLE;
        contQ <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iStart) begin
              state  <= SYNC;
              contQ  <= iContinuous;
              tmoCnt <= '0;
            end
          end
          SYNC: begin
            if (rise) begin
              state  <= MEAS;
              perCnt <= '0;
              perAcc <= '0;
              idx    <= '0;
              tmoCnt <= '0;
            end else if (tmoCnt == TMO_LAST) begin
              oTimeout <= 1'b1;
              state    <= contQ ? SYNC : IDLE;
              tmoCnt   <= '0;
            end else begin
              tmoCnt <= tmoCnt + 1'b1;
            end
          end
          MEAS: begin
            if (rise) begin
              perAcc <= accAdd(perAcc, periodSample);
              perCnt <= '0;
              idx    <= idx + 1'b1;
              tmoCnt <= '0;
              if (idx == IDX_LAST) state <= DONE;
            end else if (tmoCnt == TMO_LAST) begin
              oTimeout <= 1'b1;
              state    <= contQ ? SYNC : IDLE;
              tmoCnt   <= '0;
            end else begin
              perCnt <= satInc(perCnt);
              tmoCnt <= tmoCnt + 1'b1;
            end
          end
          DONE: begin
            // The closing edge was consumed in MEAS, so a re-arm waits for a fresh one.
            oPeriod <= truncAvg(perAcc);
            oValid  <= 1'b1;
            state   <= contQ ? SYNC : IDLE;
            tmoCnt  <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SQW_DUTY_EN
  logic             fall;
  logic             measStart;
  logic             measEdge;
  logic             doneLoad;
  logic             hiRun;
  logic [CNT_W-1:0] hiCnt;
  logic [ACC_W-1:0] hiAcc;

  assign fall      = ~sqwSync_p0[SYNC_STAGES-1] & sqwPrev_p1;
  assign measStart = (state == SYNC) & rise & ~iAbort;
  assign measEdge  = (state == MEAS) & rise & ~iAbort;
  assign doneLoad  = (state == DONE) & ~iAbort;

  // High-time counter: runs from each rising edge through the cycle of the
  // following falling edge; a missing falling edge yields the full period.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      hiRun <= 1'b0;
      hiCnt <= '0;
      hiAcc <= '0;
      oHigh <= '0;
    end else begin
      if (measStart) begin
        hiRun <= 1'b1;
        hiCnt <= '0;
        hiAcc <= '0;
      end else if (measEdge) begin
        hiAcc <= accAdd(hiAcc, hiRun ? periodSample : hiCnt);
        hiRun <= 1'b1;
        hiCnt <= '0;
      end else if (state == MEAS) begin
        if (hiRun) hiCnt <= satInc(hiCnt);
        if (fall)  hiRun <= 1'b0;
      end
      if (doneLoad) oHigh <= truncAvg(hiAcc);
    end
  end
`else
  assign oHigh = '0;
`endif

endmodule

// File: tb/tb_sqw_period_sequencer.sv
// Testbench for sqw_period_sequencer: table of single/continuous measurements
// plus directed timeout, abort and asynchronous reset sequences.
module tb_sqw_period_sequencer;

  localparam int CNT_W       = 10;
  localparam int AVG_LOG2    = 2;
  localparam int TIMEOUT_CYC = 5000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sq = 1'b0;
  logic             start = 1'b0;
  logic             cont = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high;
  logic             valid;
  logic             tmo;

  sqw_period_sequencer #(
    .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(2)
  ) dut (
    .iClk(clk), .iRst(rst), .iSquareWave(sq), .iStart(start),
    .iContinuous(cont), .iAbort(abort), .oBusy(busy), .oState(state),
    .oPeriod(period), .oHigh(high), .oValid(valid), .oTimeout(tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Square-wave generator: each queue entry is one period starting with a rise.
  int perQ[$];
  int hiQ[$];
  int gP, gH;
  bit genBusy = 1'b0;

  always begin
    if (perQ.size() != 0) begin
      genBusy = 1'b1;
      gP = perQ.pop_front();
      gH = hiQ.pop_front();
      sq = 1'b1;
      repeat (gH) @(negedge clk);
      sq = 1'b0;
      repeat (gP - gH) @(negedge clk);
    end else begin
      genBusy = 1'b0;
      @(negedge clk);
    end
  end

  task automatic pushWave(input int p, input int h);
    perQ.push_back(p);
    hiQ.push_back(h);
  endtask

  task automatic waitIdle();
    repeat (2) @(negedge clk);
    while (perQ.size() != 0 || genBusy) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  // Wait for oValid (wantTmo=0) or oTimeout (wantTmo=1), counting oValid pulses seen.
  task automatic waitFor(input bit wantTmo, input int bound, output bit found,
                         output int t, output int nValid);
    found = 1'b0;
    t = 0;
    nValid = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (valid) nValid++;
      if (wantTmo ? tmo : valid) begin
        found = 1'b1;
        t = cyc;
        break;
      end
    end
  endtask

  task automatic waitState(input string name, input logic [1:0] s, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (state == s) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, int'(seen), 1);
  endtask

  function automatic int dutyExp(input int v);
`ifdef SQW_DUTY_EN
    return v;
`else
    return 0;
`endif
  endfunction

  typedef struct {
    int p0, p1, p2, p3, tail, hi;
    bit cont;
    int expPer, expHi, expState;
    bit expBusy;
  } vec_t;

  vec_t vecs[3];

  initial begin
    bit found;
    int t, nv, tRef;

    vecs[0] = '{1000, 1000, 1000, 1000, 1000, 500, 1'b0, 1000, 500, 0, 1'b0};
    vecs[1] = '{1500, 1500, 1500, 1500, 1500, 700, 1'b0, 1023, 700, 0, 1'b0};
    vecs[2] = '{1000, 1000, 1002, 1001, 1000, 500, 1'b1, 1000, 500, 1, 1'b1};
    tRef = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_period", int'(period), 0);
    check("rst_high", int'(high), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_timeout", int'(tmo), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Table of measurements
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      cont  = vecs[v].cont;
      start = 1'b1;
      pushWave(vecs[v].p0, vecs[v].hi);
      pushWave(vecs[v].p1, vecs[v].hi);
      pushWave(vecs[v].p2, vecs[v].hi);
      pushWave(vecs[v].p3, vecs[v].hi);
      pushWave(vecs[v].tail, vecs[v].hi);
      @(negedge clk);
      start = 1'b0;
      cont  = 1'b0;
      waitFor(1'b0, 12000, found, t, nv);
      check($sformatf("vec%0d_valid_seen", v), int'(found), 1);
      tRef = t;
      check($sformatf("vec%0d_period", v), int'(period), vecs[v].expPer);
      check($sformatf("vec%0d_high", v), int'(high), dutyExp(vecs[v].expHi));
      check($sformatf("vec%0d_state", v), int'(state), vecs[v].expState);
      check($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].expBusy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid_pulse", v), int'(valid), 0);
      if (!vecs[v].cont) waitIdle();
    end

    // Continuous re-arm with no further edges: timeout 5000 cycles after SYNC entry
    waitFor(1'b1, 7000, found, t, nv);
    check("cont_tmo_seen", int'(found), 1);
    check("cont_tmo_delay", t - tRef, TIMEOUT_CYC);
    check("cont_tmo_novalid", nv, 0);
    check("cont_tmo_period", int'(period), 1000);
    check("cont_tmo_state", int'(state), 1);
    check("cont_tmo_busy", int'(busy), 1);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("cont_abort_state", int'(state), 0);
    @(negedge clk);
    abort = 1'b0;
    waitIdle();

    // Abort with simultaneous iStart during MEAS, then a fresh measurement
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 12; i++) pushWave(800, 400);
    @(negedge clk);
    start = 1'b0;
    waitState("abort_reach_meas", 2'd2, 100);
    repeat (1500) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_state", int'(state), 0);
    check("abort_busy", int'(busy), 0);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    waitFor(1'b0, 1000, found, t, nv);
    check("abort_novalid", nv, 0);
    check("abort_notmo", int'(tmo), 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitFor(1'b0, 8000, found, t, nv);
    check("fresh_valid_seen", int'(found), 1);
    check("fresh_period", int'(period), 800);
    check("fresh_high", int'(high), dutyExp(400));
    waitIdle();

    // Single-shot timeout with input held low
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("tmo_enter_sync", int'(state), 1);
    tRef = cyc;
    @(negedge clk);
    start = 1'b0;
    waitFor(1'b1, 7000, found, t, nv);
    check("tmo_seen", int'(found), 1);
    check("tmo_delay", t - tRef, TIMEOUT_CYC);
    check("tmo_novalid", nv, 0);
    check("tmo_period", int'(period), 800);
    check("tmo_state", int'(state), 0);
    @(posedge clk);
    #1;
    check("tmo_pulse", int'(tmo), 0);

    // Asynchronous reset pulse between clock edges during MEAS
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 5; i++) pushWave(1000, 500);
    @(negedge clk);
    start = 1'b0;
    waitState("arst_reach_meas", 2'd2, 100);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    check("arst_state", int'(state), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_period", int'(period), 0);
    check("arst_high", int'(high), 0);
    check("arst_valid", int'(valid), 0);
    check("arst_timeout", int'(tmo), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("arst_stay_idle", int'(state), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
